count_sseg_driver: RTL and testbench



---
 rtl/count_sseg_driver_pkg.sv | 50 +++++
 rtl/count_sseg_driver_if.sv | 23 ++
 rtl/count_sseg_driver_bin2bcd_seq.sv | 101 ++++++++++
 rtl/count_sseg_driver.sv | 100 ++++++++++
 tb/tb_count_sseg_driver.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/count_sseg_driver_pkg.sv
// Shared types, segment codes and the BCD-to-segment decoder for the
// count display path.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Binary input width and BCD field width (four decimal digits)
    localparam int CNT_W       = 14;
    localparam int BCD_W       = 16;
    localparam int CONV_CYCLES = 14;
    localparam int MAX_DISP    = 9999;

    // Active-low cathodes {dp,g,f,e,d,c,b,a}; DP always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'b1011_1111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal nibbles render as blank rather than garbage
    function automatic logic [7:0] bcd_to_sseg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/count_sseg_driver_if.sv
// Bus between the count register writer and the seven-segment driver.
interface count_sseg_driver_if;
    import sseg_pkg::*;

    logic [CNT_W-1:0] count;
    logic             load;
    logic             busy;
    logic [7:0]       segs;
    logic [3:0]       an;

    // Writer side (IOBUS / testbench)
    modport master (
        output count, load,
        input  busy, segs, an
    );

    // Driver side
    modport slave (
        input  count, load,
        output busy, segs, an
    );

endinterface

// File: rtl/count_sseg_driver_bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep pending slot.
// Loads arriving while a conversion is running are parked in the
// pending register (latest wins) and started straight from COMMIT.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic             clk,
    input  logic             RST_N,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_busy,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_ovf,
    output logic             o_commit
);

    localparam int SR_W = BCD_W + CNT_W;

    conv_state_t      r_state;
    logic [SR_W-1:0]  r_sr;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_val;
    logic             r_pend;
    logic [CNT_W-1:0] r_pval;
    logic             r_busy;

    logic [SR_W-1:0]  w_adj;

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_sr[CNT_W + 4*i +: 4] >= 4'd5)
                w_adj[CNT_W + 4*i +: 4] = r_sr[CNT_W + 4*i +: 4] + 4'd3;
        end
    end

    // Converter FSM, shift register and pending slot
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_val   <= '0;
            r_pend  <= 1'b0;
            r_pval  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A load arriving at COMMIT may be waiting here
                    if (i_load || r_pend) begin
                        r_sr    <= {{BCD_W{1'b0}}, (i_load ? i_count : r_pval)};
                        r_val   <= i_load ? i_count : r_pval;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr  <= {w_adj[SR_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (i_load) begin
                        r_pend <= 1'b1;
                        r_pval <= i_count;
                    end
                    if (r_cnt == 4'(CONV_CYCLES - 1))
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    if (r_pend) begin
                        // Chain straight into the parked value, no IDLE gap
                        r_sr    <= {{BCD_W{1'b0}}, r_pval};
                        r_val   <= r_pval;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    // A load coinciding with COMMIT always becomes pending
                    r_pend <= i_load;
                    if (i_load)
                        r_pval <= i_count;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_bcd    = r_sr[SR_W-1:CNT_W];
    assign o_ovf    = (r_val > CNT_W'(MAX_DISP));
    assign o_commit = (r_state == COMMIT);

endmodule

// File: rtl/count_sseg_driver.sv
// Seven-segment driver for the COUNT register: converts the binary count
// to BCD, latches the digits atomically on commit and scans them onto the
// four-digit display with optional leading-zero blanking.
module count_sseg_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_BLANK    = 1
) (
    input  logic               clk,
    input  logic               RST_N,
    count_sseg_driver_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic             w_busy;
    logic [BCD_W-1:0] w_bcd;
    logic             w_ovf;
    logic             w_commit;

    logic [3:0][3:0]  r_digits;
    logic             r_ovf;
    logic [CW-1:0]    r_rcnt;
    logic [1:0]       r_idx;
    logic [7:0]       r_segs;
    logic [3:0]       r_an;

    logic [3:0]       w_digit;
    logic             w_upper_zero;
    logic             w_blank;
    logic [7:0]       w_seg;

    bin2bcd_seq u_conv (
        .clk      (clk),
        .RST_N    (RST_N),
        .i_load   (bus.load),
        .i_count  (bus.count),
        .o_busy   (w_busy),
        .o_bcd    (w_bcd),
        .o_ovf    (w_ovf),
        .o_commit (w_commit)
    );

    // Display digits only change on commit so a scan never tears
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else if (w_commit) begin
            r_digits <= w_bcd;
            r_ovf    <= w_ovf;
        end
    end

    // Free-running refresh divider stepping the scan index on wrap
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_rcnt <= '0;
            r_idx  <= '0;
        end else if (r_rcnt == CW'(REFRESH_DIV - 1)) begin
            r_rcnt <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    // Digit select, leading-zero test and segment decode for current slot
    always_comb begin
        w_digit = r_digits[r_idx];
        case (r_idx)
            2'd1:    w_upper_zero = (r_digits[3:1] == '0);
            2'd2:    w_upper_zero = (r_digits[3:2] == '0);
            2'd3:    w_upper_zero = (r_digits[3] == '0);
            default: w_upper_zero = 1'b0;
        endcase
        w_blank = (LZ_BLANK != 0) && !r_ovf && w_upper_zero;
        w_seg   = r_ovf ? SEG_DASH : bcd_to_sseg(w_digit);
    end

    // Registered anode/cathode outputs
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_segs <= SEG_BLANK;
            r_an   <= 4'hF;
        end else if (w_blank) begin
            r_segs <= SEG_BLANK;
            r_an   <= 4'hF;
        end else begin
            r_segs <= w_seg;
            r_an   <= ~(4'b0001 << r_idx);
        end
    end

    assign bus.busy = w_busy;
    assign bus.segs = r_segs;
    assign bus.an   = r_an;

endmodule

// File: tb/tb_count_sseg_driver.sv
// Directed bench for count_sseg_driver with a short refresh period.
module tb_count_sseg_driver;

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0,
                           S4 = 8'h99, S5 = 8'h92, S7 = 8'hF8, S9 = 8'h90,
                           SD = 8'hBF, BL = 8'hFF;

    logic clk;
    logic RST_N;
    int   nchk;
    int   nfail;

    count_sseg_driver_if bus ();

    count_sseg_driver #(.REFRESH_DIV(4), .LZ_BLANK(1)) dut (
        .clk   (clk),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0]     cnt;
        logic [3:0][7:0] exp;
        string           nm;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Watch 32 cycles (two full scans); exp[k]==BL means slot k must stay dark
    task automatic scan_check(input logic [3:0][7:0] exp, input string nm);
        int         bad;
        bit         seen[4];
        logic [3:0] onehot;
        logic [3:0] lan;
        logic [7:0] lsegs;
        int         k;
        bad = 0;
        lan = 4'h0;
        lsegs = 8'h0;
        for (int j = 0; j < 4; j++) seen[j] = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (bus.an == 4'hF) begin
                if (bus.segs != BL) begin bad++; lan = bus.an; lsegs = bus.segs; end
            end else begin
                k = -1;
                for (int j = 0; j < 4; j++) begin
                    onehot = ~(4'b0001 << j);
                    if (bus.an == onehot) k = j;
                end
                if (k < 0) begin
                    bad++; lan = bus.an; lsegs = bus.segs;
                end else begin
                    seen[k] = 1'b1;
                    if (exp[k] == BL || bus.segs != exp[k]) begin
                        bad++; lan = bus.an; lsegs = bus.segs;
                    end
                end
            end
        end
        nchk++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL %s scan: %0d bad samples, last an=%b segs=%h", nm, bad, lan, lsegs);
        end
        for (int j = 0; j < 4; j++) begin
            nchk++;
            if (seen[j] != (exp[j] != BL)) begin
                nfail++;
                $display("FAIL %s slot%0d: lit=%0d required lit=%0d", nm, j, seen[j], exp[j] != BL);
            end
        end
    endtask

    // Pulse load for one edge (E0), then check busy across the conversion
    task automatic load_and_time(input logic [13:0] v, input string nm);
        bus.count = v;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        chk({nm, " busy@E0"}, 32'(bus.busy), 32'd1);
        repeat (14) @(posedge clk);
        #1 chk({nm, " busy@E0+14"}, 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 chk({nm, " busy@E0+15"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int busy_bad;
        int dig_bad;
        nchk  = 0;
        nfail = 0;

        tv[0] = '{14'd1234,  {S1, S2, S3, S4}, "1234"};
        tv[1] = '{14'd305,   {BL, S3, S0, S5}, "305"};
        tv[2] = '{14'd7,     {BL, BL, BL, S7}, "7"};
        tv[3] = '{14'd1000,  {S1, S0, S0, S0}, "1000"};
        tv[4] = '{14'd9999,  {S9, S9, S9, S9}, "9999"};
        tv[5] = '{14'd10000, {SD, SD, SD, SD}, "10000"};
        tv[6] = '{14'd16383, {SD, SD, SD, SD}, "16383"};

        // Reset values
        RST_N     = 1'b0;
        bus.load  = 1'b0;
        bus.count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst segs", 32'(bus.segs), 32'hFF);
        chk("rst an",   32'(bus.an),   32'hF);
        RST_N = 1'b1;
        scan_check({BL, BL, BL, S0}, "idle");
        chk("idle busy", 32'(bus.busy), 32'd0);

        // Table of single conversions
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            load_and_time(tv[i].cnt, tv[i].nm);
            repeat (3) @(posedge clk);
            scan_check(tv[i].exp, tv[i].nm);
        end

        // Back-to-back loads: 1111 at E0, 2222 at E0+3, 3333 at E0+5
        @(posedge clk); #1;
        bus.count = 14'd1111;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        busy_bad = 0;
        dig_bad  = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin bus.count = 14'd2222; bus.load = 1'b1; end
            if (c == 5) begin bus.count = 14'd3333; bus.load = 1'b1; end
            @(posedge clk); #1;
            bus.load = 1'b0;
            if (c < 30 && bus.busy !== 1'b1) busy_bad++;
            if (c >= 17 && c <= 29 && bus.an != 4'hF && bus.segs != S1) dig_bad++;
        end
        chk("pend busy continuous", 32'(busy_bad), 32'd0);
        chk("pend first shows 1111", 32'(dig_bad), 32'd0);
        chk("pend busy@E0+30", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        scan_check({S3, S3, S3, S3}, "pend 3333");

        // Reset in the middle of converting 4321
        @(posedge clk); #1;
        bus.count = 14'd4321;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        repeat (6) @(posedge clk);
        #1 RST_N = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst segs", 32'(bus.segs), 32'hFF);
        chk("midrst an",   32'(bus.an),   32'hF);
        RST_N = 1'b1;
        busy_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0) busy_bad++;
        end
        chk("midrst no restart", 32'(busy_bad), 32'd0);
        scan_check({BL, BL, BL, S0}, "midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
